// File: rtl/pl0_stall_gen.sv
// pl0_stall_gen: decodes the instruction at the current fetch PC and drives the
// pl0 fetch stall interface, so that jumps, branches, JALR and loads sequence the
// PC correctly. Multi-cycle stalls are tracked here, so an instruction held at a
// frozen PC is decoded only once. Saturating stall and retire counters are kept
// alongside.
module pl0_stall_gen #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_instr_val,
    input  logic             i_mem_wait,
    output logic [2:0]       o_stall_state,
    output logic             o_stall_active,
    output logic             o_retire,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_retire_count
);

    // Encoding of pl0_stall_state as seen by pl0_fetch.i_stall_state
    localparam logic [2:0] PL0_STALL_NONE     = 3'd0;
    localparam logic [2:0] PL0_STALL_IMM      = 3'd1;
    localparam logic [2:0] PL0_STALL_1        = 3'd2;
    localparam logic [2:0] PL0_STALL_1_BRANCH = 3'd3;
    localparam logic [2:0] PL0_STALL_1_ALU    = 3'd4;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    // The freeze counter never needs to exceed LOAD_STALL_CYCLES
    localparam int              CNT_HW = $clog2(LOAD_STALL_CYCLES + 2);
    localparam logic [CNT_HW-1:0] LSC_C  = CNT_HW'(LOAD_STALL_CYCLES);
    localparam logic [CNT_HW-1:0] CNT_ONE = CNT_HW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SHADOW = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_eff;
    state_t              w_state_next;
    logic [CNT_HW-1:0]   r_cnt;
    logic [CNT_HW-1:0]   w_cnt_next;
    logic [CNT_HW-1:0]   w_cnt_inc;
    logic [2:0]          w_decoded;
    logic                w_retire;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic [CNT_W-1:0]    r_retire_count;

    // Maps an instruction word to the stall request it needs when first seen
    function automatic logic [2:0] decode_stall(input logic [31:0] instr);
        logic [2:0] res;
        case (instr[6:0])
            OP_JAL:    res = PL0_STALL_IMM;
            OP_BRANCH: res = PL0_STALL_1_BRANCH;
            OP_JALR:   res = PL0_STALL_1_ALU;
            OP_LOAD:   res = PL0_STALL_1;
            default:   res = PL0_STALL_NONE;
        endcase
        return res;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        if (&v) begin
            res = v;
        end else begin
            res = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    assign w_decoded = decode_stall(i_instr_val);
    assign w_cnt_inc = r_cnt + CNT_ONE;

    // Next-state and Mealy outputs; while reset is high the decode behaves as IDLE
    always_comb begin
        w_state_eff   = i_rst ? ST_IDLE : r_state;
        w_state_next  = ST_IDLE;
        w_cnt_next    = r_cnt;
        o_stall_state = PL0_STALL_NONE;
        w_retire      = 1'b0;

        case (w_state_eff)
            ST_IDLE: begin
                o_stall_state = w_decoded;
                case (w_decoded)
                    PL0_STALL_IMM: begin
                        w_retire     = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                    PL0_STALL_1_BRANCH,
                    PL0_STALL_1_ALU: begin
                        w_state_next = ST_SHADOW;
                    end
                    PL0_STALL_1: begin
                        if ((LOAD_STALL_CYCLES == 1) && !i_mem_wait) begin
                            w_state_next = ST_SHADOW;
                        end else begin
                            w_state_next = ST_HOLD;
                            w_cnt_next   = CNT_ONE;
                        end
                    end
                    default: begin
                        w_retire     = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                endcase
            end
            ST_HOLD: begin
                // Load still at PC: keep the fetch frozen; memory wait stalls the count
                o_stall_state = PL0_STALL_1;
                w_state_next  = ST_HOLD;
                if (!i_mem_wait) begin
                    if (w_cnt_inc >= LSC_C) begin
                        w_state_next = ST_SHADOW;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
            end
            ST_SHADOW: begin
                // Fetch finishes its own follow-up; the instruction leaves PC now
                o_stall_state = PL0_STALL_NONE;
                w_retire      = 1'b1;
                w_state_next  = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign o_retire       = w_retire & ~i_rst;
    assign o_stall_active = (o_stall_state != PL0_STALL_NONE) || (w_state_eff == ST_SHADOW);

    // State register and load freeze counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Saturating performance counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
            r_retire_count <= '0;
        end else begin
            if (o_stall_active) begin
                r_stall_cycles <= sat_inc(r_stall_cycles);
            end
            if (o_retire) begin
                r_retire_count <= sat_inc(r_retire_count);
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_retire_count = r_retire_count;

endmodule

// File: tb/tb_pl0_stall_gen.sv
// Bench for pl0_stall_gen: a cycle model tracking "pending shadow" and "freeze
// cycles still owed" is compared with the DUT on every negative edge, and
// directed sequences carry hand-computed literal expectations.
module tb_pl0_stall_gen;

    localparam int LSC = 3;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    localparam int S_NONE = 0;
    localparam int S_IMM  = 1;
    localparam int S_1    = 2;
    localparam int S_BR   = 3;
    localparam int S_ALU  = 4;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] BEQ  = 32'h00000463;
    localparam logic [31:0] JALR = 32'h000080E7;
    localparam logic [31:0] JAL  = 32'h008000EF;
    localparam logic [31:0] LW   = 32'h0000A103;
    localparam logic [31:0] ILL  = 32'h00000000;

    logic          clk = 1'b1;
    logic          rst;
    logic [31:0]   instr;
    logic          mw;
    logic [2:0]    st;
    logic          active;
    logic          retire;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] ret_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    bit started  = 0;
    bit m_shadow = 0;
    int m_left   = 0;
    int m_stall  = 0;
    int m_ret    = 0;

    pl0_stall_gen #(.LOAD_STALL_CYCLES(LSC), .CNT_W(CW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_instr_val    (instr),
        .i_mem_wait     (mw),
        .o_stall_state  (st),
        .o_stall_active (active),
        .o_retire       (retire),
        .o_stall_cycles (stall_cnt),
        .o_retire_count (ret_cnt)
    );

    always #5 clk = ~clk;

    function automatic int f_dec(input logic [31:0] ins);
        case (ins[6:0])
            7'b1101111: return S_IMM;
            7'b1100011: return S_BR;
            7'b1100111: return S_ALU;
            7'b0000011: return S_1;
            default:    return S_NONE;
        endcase
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model across the next edge
    always @(negedge clk) begin
        int d;
        int es;
        int er;
        int ea;
        d = f_dec(instr);
        if (rst) started = 1;
        if (rst) begin
            es = d; er = 0; ea = (d != S_NONE);
        end else if (m_shadow) begin
            es = S_NONE; er = 1; ea = 1;
        end else if (m_left > 0) begin
            es = S_1; er = 0; ea = 1;
        end else begin
            es = d; er = (d == S_NONE || d == S_IMM); ea = (d != S_NONE);
        end
        if (started) begin
            check("stall_state", int'(st), es);
            check("stall_active", int'(active), ea);
            check("retire", int'(retire), er);
            if (!rst) begin
                check("stall_cycles", int'(stall_cnt), (m_stall > SAT) ? SAT : m_stall);
                check("retire_count", int'(ret_cnt), (m_ret > SAT) ? SAT : m_ret);
            end
        end
        if (rst) begin
            m_shadow = 0; m_left = 0; m_stall = 0; m_ret = 0;
        end else begin
            m_stall += ea;
            m_ret   += er;
            if (m_shadow) begin
                m_shadow = 0;
            end else if (m_left > 0) begin
                if (!mw) begin
                    m_left--;
                    if (m_left == 0) m_shadow = 1;
                end
            end else if (d == S_BR || d == S_ALU) begin
                m_shadow = 1;
            end else if (d == S_1) begin
                if (LSC > 1) m_left = LSC - 1;
                else if (mw) m_left = 1;
                else m_shadow = 1;
            end
        end
    end

    // One clock cycle of stimulus; exp_st >= 0 also pins the stall state literally
    task automatic cyc(input logic [31:0] ins, input logic w, input logic r, input int exp_st);
        instr = ins; mw = w; rst = r;
        #1;
        if (exp_st >= 0) check("lit_state", int'(st), exp_st);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; instr = ADDI; mw = 1'b0;

        // 1: straight-line instructions retire every cycle
        cyc(ADDI, 0, 1, S_NONE);
        cyc(ADDI, 0, 0, S_NONE);
        cyc(ADDI, 1, 0, S_NONE);
        cyc(ADDI, 0, 0, S_NONE);
        check("t1_retire_count", int'(ret_cnt), 3);
        check("t1_stall_cycles", int'(stall_cnt), 0);

        // 2: branch freezes then shadows
        cyc(BEQ, 0, 1, -1);
        cyc(BEQ, 0, 0, S_BR);
        cyc(BEQ, 0, 0, S_NONE);
        check("t2_stall_cycles", int'(stall_cnt), 2);
        check("t2_retire_count", int'(ret_cnt), 1);

        // 3: JALR, JAL, undefined opcode
        cyc(JALR, 0, 1, -1);
        cyc(JALR, 0, 0, S_ALU);
        cyc(JALR, 0, 0, S_NONE);
        cyc(JAL,  0, 0, S_IMM);
        cyc(ILL,  0, 0, S_NONE);
        check("t3_retire_count", int'(ret_cnt), 3);
        check("t3_stall_cycles", int'(stall_cnt), 3);

        // 4: load with two memory-wait cycles in the hold
        cyc(LW, 0, 1, -1);
        cyc(LW, 0, 0, S_1);
        cyc(LW, 0, 0, S_1);
        cyc(LW, 1, 0, S_1);
        cyc(LW, 1, 0, S_1);
        cyc(LW, 0, 0, S_1);
        cyc(LW, 0, 0, S_NONE);
        check("t4_stall_cycles", int'(stall_cnt), 6);
        check("t4_retire_count", int'(ret_cnt), 1);

        // 5: reset during shadow abandons it; the branch is decoded afresh
        cyc(BEQ, 0, 1, -1);
        cyc(BEQ, 0, 0, S_BR);
        cyc(BEQ, 0, 1, S_BR);
        check("t5_stall_after_rst", int'(stall_cnt), 0);
        check("t5_retire_after_rst", int'(ret_cnt), 0);
        cyc(BEQ, 0, 0, S_BR);
        check("t5_stall_cycles", int'(stall_cnt), 1);

        // 6: counters saturate
        cyc(ADDI, 0, 1, -1);
        for (int i = 0; i < 20; i++) cyc(ADDI, 0, 0, -1);
        check("t6_retire_sat", int'(ret_cnt), 15);
        check("t6_stall_zero", int'(stall_cnt), 0);
        for (int i = 0; i < 20; i++) cyc(JAL, 0, 0, -1);
        check("t6_stall_sat", int'(stall_cnt), 15);
        check("t6_retire_hold", int'(ret_cnt), 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
